nios2_ram_arbiter: RTL
======================

Name: nios2_ram_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single-port on-chip NIOS2 program/data RAM (32-bit, 15-bit word address, byte enables, 1-cycle read latency) between the CPU data master (m0) and a DMA master (m1).
- Issues at most one RAM access per cycle using round-robin or fixed-priority grant.
- Returns read data to the issuing master with a readdatavalid strobe.
- Sits between the interconnect and the RAM's single slave port; the RAM sees one master.

Parameters:
- ADDR_W, 15, word-address width of the RAM and both masters.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- NUMWORDS, 20480, implemented RAM depth; addresses >= NUMWORDS are out of range.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority with m0 highest.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  write byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_clken  out  1  to RAM clken; tied 1.
- ram_readdata  in  DATA_W  RAM read data, valid 1 cycle after a read is issued.

Behaviour:
- Request: req_n = mn_read | mn_write. If both read and write are high, treat as a write; the read is ignored.
- Grant is combinational each cycle.
  - PRIORITY_MODE 1: m0 wins whenever req_0.
  - PRIORITY_MODE 0: with a single requester, it wins. With both, the master not granted last wins.
- last_grant register: updates on every accepted transfer; resets to 1, so m0 wins the first contention.
- mn_waitrequest = reset | (req_n & ~grant_n). With no request it is 0, except during reset, when both are 1.
- Accepted transfer: grant_n & ~reset. Drive ram_* from the granted master in the same cycle.
  - ram_chipselect=1 and ram_write=write only if address < NUMWORDS.
  - Otherwise ram_chipselect=0: an out-of-range write is dropped but still accepted.
- Read pipeline registers rd_valid, rd_owner, rd_oor; all reset to 0. They are set on an accepted read.
- Next cycle: owner's readdatavalid=1. Its readdata = ram_readdata, or 0 if rd_oor. The other master's readdatavalid=0.
- readdata is 0 whenever readdatavalid=0.
- Back-to-back reads: a new read may be accepted every cycle. Throughput is 1/cycle total, latency exactly 1 cycle.
- A read and a write from different masters never issue in the same cycle; the loser stalls.
- Idle: ram_chipselect=0, ram_write=0, ram_address/byteenable/writedata=0.
- Reset mid-operation: all pipeline registers clear immediately (async). Any pending readdatavalid is lost and the master must reissue. last_grant returns to 1.
- No writes reach the RAM while reset is high.

Test Plan:
- Reset then m0 read addr 0x0010, RAM word 0xDEADBEEF -> m0_waitrequest=0 on issue; next cycle m0_readdatavalid=1, m0_readdata=0xDEADBEEF; m1_readdatavalid=0.
- m0 and m1 both write continuously for 4 cycles (addrs 0x100.., 0x200..), round-robin -> grants alternate m0,m1,m0,m1; each master sees waitrequest=1 on alternate cycles; RAM gets 4 writes in order.
- Same stimulus with PRIORITY_MODE=1 -> m0 gets all 4 cycles; m1_waitrequest=1 throughout; m1 granted on cycle 5 after m0 drops its request.
- m1 write byteenable=4'b0010, writedata=0x0000AB00 to 0x0050 (held 0x11223344), then m0 reads 0x0050 -> m0_readdata=0x1122AB44.
- m0 read addr 20480 (0x5000) -> accepted, ram_chipselect=0, next cycle m0_readdatavalid=1 with readdata=0; m1 write to 0x5001 -> accepted, RAM unchanged.
- m1 read accepted, reset pulsed in the following cycle -> m1_readdatavalid stays 0; both waitrequests=1 during reset; after release, a contended request grants m0 first.

Source files
------------

// File: rtl/nios2_ram_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port NIOS2 on-chip RAM.
// One access per cycle, combinational grant, 1-cycle read return to the issuing master.
module nios2_ram_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 32,
    parameter int NUMWORDS      = 20480,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W:0] NUMWORDS_W = (ADDR_W + 1)'(NUMWORDS);

    logic [ADDR_W-1:0] mst_addr  [2];
    logic [BE_W-1:0]   mst_be    [2];
    logic [DATA_W-1:0] mst_wdata [2];
    logic [DATA_W-1:0] rdata_out [2];
    logic [1:0]        mst_read;
    logic [1:0]        mst_write;
    logic [1:0]        req;
    logic [1:0]        in_range;
    logic [1:0]        grant;
    logic [1:0]        waitreq;
    logic [1:0]        rvalid;

    logic              accept;
    logic              sel;
    logic [DATA_W-1:0] ret_data;

    logic last_grant_q, last_grant_d;
    logic rd_valid_q,   rd_valid_d;
    logic rd_owner_q,   rd_owner_d;
    logic rd_oor_q,     rd_oor_d;

    assign mst_addr[0]  = m0_address;
    assign mst_addr[1]  = m1_address;
    assign mst_be[0]    = m0_byteenable;
    assign mst_be[1]    = m1_byteenable;
    assign mst_wdata[0] = m0_writedata;
    assign mst_wdata[1] = m1_writedata;
    assign mst_read     = {m1_read, m0_read};
    assign mst_write    = {m1_write, m0_write};

    // Out-of-range returns are forced to zero instead of exposing stale RAM output.
    assign ret_data = rd_oor_q ? '0 : ram_readdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_mst
        assign req[gi]       = mst_read[gi] | mst_write[gi];
        assign in_range[gi]  = ({1'b0, mst_addr[gi]} < NUMWORDS_W);
        assign waitreq[gi]   = reset | (req[gi] & ~grant[gi]);
        assign rvalid[gi]    = rd_valid_q & (rd_owner_q == 1'(gi));
        assign rdata_out[gi] = rvalid[gi] ? ret_data : '0;
    end

    if (PRIORITY_MODE == 1) begin : g_fixed
        assign grant[0] = req[0];
        assign grant[1] = req[1] & ~req[0];
    end else begin : g_rr
        // Under contention the master that was not served last goes next.
        always_comb begin
            grant = req;
            if (&req) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end
        end
    end

    assign accept = (|grant) & ~reset;
    assign sel    = grant[1];

    always_comb begin
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        last_grant_d   = last_grant_q;
        rd_valid_d     = 1'b0;
        rd_owner_d     = rd_owner_q;
        rd_oor_d       = rd_oor_q;
        if (accept) begin
            ram_address    = mst_addr[sel];
            ram_byteenable = mst_be[sel];
            ram_writedata  = mst_wdata[sel];
            ram_chipselect = in_range[sel];
            ram_write      = mst_write[sel] & in_range[sel];
            last_grant_d   = sel;
            // Write wins when read and write are both asserted.
            if (!mst_write[sel]) begin
                rd_valid_d = 1'b1;
                rd_owner_d = sel;
                rd_oor_d   = ~in_range[sel];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    assign ram_clken        = 1'b1;
    assign m0_waitrequest   = waitreq[0];
    assign m1_waitrequest   = waitreq[1];
    assign m0_readdatavalid = rvalid[0];
    assign m1_readdatavalid = rvalid[1];
    assign m0_readdata      = rdata_out[0];
    assign m1_readdata      = rdata_out[1];

endmodule
